// File: rtl/escape_pkg.sv
// Shared types and constants for the escape-time iterator.
package escape_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MANDEL = 1'b0,
    MODE_JULIA  = 1'b1
  } mode_t;

  // 4.0 expressed in the Q(2*FRAC) format of a full-width square.
  function automatic logic [127:0] esc_thresh(input int frac);
    return 128'd4 << (2 * frac);
  endfunction

endpackage

// File: rtl/escape_time_engine_fx_csq_add.sv
// Combinational z^2 + c with saturation to DW bits, plus exact |z|^2 at 2*DW+1 bits.
// Zero latency, no flow control.
module fx_csq_add #(
  parameter int DW   = 32,
  parameter int FRAC = 16
) (
  input  logic [DW-1:0] z_re,
  input  logic [DW-1:0] z_im,
  input  logic [DW-1:0] c_re,
  input  logic [DW-1:0] c_im,
  output logic [DW-1:0] n_re,
  output logic [DW-1:0] n_im,
  output logic [2*DW:0] mag2
);

  localparam int PW = 2 * DW;

  logic signed [PW-1:0] re2, im2, reim;
  logic        [DW-1:0] re2_s, im2_s, reim_s;
  logic signed [DW+1:0] sum_re, sum_im;

  function automatic logic [DW-1:0] sat(input logic [DW+1:0] v);
    if (v[DW+1:DW-1] == 3'b000 || v[DW+1:DW-1] == 3'b111) return v[DW-1:0];
    else if (v[DW+1]) return {1'b1, {(DW-1){1'b0}}};
    else return {1'b0, {(DW-1){1'b1}}};
  endfunction

  always_comb begin
    re2    = PW'($signed(z_re)) * PW'($signed(z_re));
    im2    = PW'($signed(z_im)) * PW'($signed(z_im));
    reim   = PW'($signed(z_re)) * PW'($signed(z_im));
    mag2   = {re2[PW-1], re2} + {im2[PW-1], im2};
    // Rescale keeps product bits [DW+FRAC-1:FRAC]; sums run 2 bits wider so they never wrap.
    re2_s  = DW'(re2 >>> FRAC);
    im2_s  = DW'(im2 >>> FRAC);
    reim_s = DW'(reim >>> FRAC);
    sum_re = {{2{re2_s[DW-1]}}, re2_s} - {{2{im2_s[DW-1]}}, im2_s}
           + {{2{c_re[DW-1]}}, c_re};
    sum_im = {reim_s[DW-1], reim_s, 1'b0} + {{2{c_im[DW-1]}}, c_im};
    n_re   = sat(sum_re);
    n_im   = sat(sum_im);
  end

endmodule

// File: rtl/escape_time_engine.sv
// Escape-time iterator: accept in IDLE, one iteration per cycle, result valid depth+1 edges later.
// Result held in DONE until out_ready; in_ready only in IDLE.
module escape_time_engine
  import escape_pkg::*;
#(
  parameter int DW     = 32,
  parameter int FRAC   = 16,
  parameter int ITER_W = 10,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XW-1:0]     in_x,
  input  logic [YW-1:0]     in_y,
  input  logic [DW-1:0]     in_re_p,
  input  logic [DW-1:0]     in_im_p,
  input  logic              in_julia,
  input  logic [DW-1:0]     jul_re,
  input  logic [DW-1:0]     jul_im,
  input  logic [ITER_W-1:0] max_iter,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XW-1:0]     out_x,
  output logic [YW-1:0]     out_y,
  output logic [ITER_W-1:0] out_depth,
  output logic              out_escaped
);

  localparam logic [2*DW:0] THR = (2*DW+1)'(esc_thresh(FRAC));

  state_t              state_q, state_d;
  logic [DW-1:0]       z_re_q, z_re_d, z_im_q, z_im_d;
  logic [DW-1:0]       c_re_q, c_re_d, c_im_q, c_im_d;
  logic [ITER_W-1:0]   depth_q, depth_d, max_q, max_d;
  logic [ITER_W-1:0]   out_depth_q, out_depth_d;
  logic                out_esc_q, out_esc_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [DW-1:0]       n_re, n_im;
  logic [2*DW:0]       mag2;
  logic                esc;
  mode_t               mode;

  fx_csq_add #(.DW(DW), .FRAC(FRAC)) u_csq (
    .z_re (z_re_q),
    .z_im (z_im_q),
    .c_re (c_re_q),
    .c_im (c_im_q),
    .n_re (n_re),
    .n_im (n_im),
    .mag2 (mag2)
  );

  assign esc  = mag2 > THR;
  assign mode = in_julia ? MODE_JULIA : MODE_MANDEL;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= IDLE;
      z_re_q      <= '0;
      z_im_q      <= '0;
      c_re_q      <= '0;
      c_im_q      <= '0;
      depth_q     <= '0;
      max_q       <= '0;
      out_depth_q <= '0;
      out_esc_q   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      z_re_q      <= z_re_d;
      z_im_q      <= z_im_d;
      c_re_q      <= c_re_d;
      c_im_q      <= c_im_d;
      depth_q     <= depth_d;
      max_q       <= max_d;
      out_depth_q <= out_depth_d;
      out_esc_q   <= out_esc_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    z_re_d      = z_re_q;
    z_im_d      = z_im_q;
    c_re_d      = c_re_q;
    c_im_d      = c_im_q;
    depth_d     = depth_q;
    max_d       = max_q;
    out_depth_d = out_depth_q;
    out_esc_d   = out_esc_q;
    x_d         = x_q;
    y_d         = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ITER;
          x_d     = in_x;
          y_d     = in_y;
          max_d   = max_iter;
          depth_d = '0;
          if (mode == MODE_JULIA) begin
            z_re_d = in_re_p;
            z_im_d = in_im_p;
            c_re_d = jul_re;
            c_im_d = jul_im;
          end else begin
            z_re_d = '0;
            z_im_d = '0;
            c_re_d = in_re_p;
            c_im_d = in_im_p;
          end
        end
      end
      ITER: begin
        // Escape test wins over the iteration limit.
        if (esc) begin
          out_depth_d = depth_q;
          out_esc_d   = 1'b1;
          state_d     = DONE;
        end else if (depth_q == max_q) begin
          out_depth_d = max_q;
          out_esc_d   = 1'b0;
          state_d     = DONE;
        end else begin
          z_re_d  = n_re;
          z_im_d  = n_im;
          depth_d = depth_q + ITER_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    out_x       = x_q;
    out_y       = y_q;
    out_depth   = out_depth_q;
    out_escaped = out_esc_q;
  end

endmodule

// File: tb/tb_escape_time_engine.sv
// Directed bench for escape_time_engine (DW=32, FRAC=16).
module tb_escape_time_engine;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_x;
  logic [8:0]  in_y;
  logic [31:0] in_re_p, in_im_p;
  logic        in_julia;
  logic [31:0] jul_re, jul_im;
  logic [9:0]  max_iter;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_x;
  logic [8:0]  out_y;
  logic [9:0]  out_depth;
  logic        out_escaped;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] FX_0   = 32'h0000_0000;
  localparam logic [31:0] FX_1P5 = 32'h0001_8000;
  localparam logic [31:0] FX_2   = 32'h0002_0000;
  localparam logic [31:0] FX_3   = 32'h0003_0000;
  localparam logic [31:0] FX_M2  = 32'hFFFE_0000;
  localparam logic [31:0] FX_30K = 32'h7530_0000;
  localparam logic [31:0] FX_BIG = 32'h7FFF_0000;

  always #5 sysclk = ~sysclk;

  escape_time_engine dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_re_p     (in_re_p),
    .in_im_p     (in_im_p),
    .in_julia    (in_julia),
    .jul_re      (jul_re),
    .jul_im      (jul_im),
    .max_iter    (max_iter),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_depth   (out_depth),
    .out_escaped (out_escaped)
  );

  // Launches one job and waits for out_valid; lat = edges after the accepting edge, -1 on timeout.
  task automatic start_job(input logic [9:0] x, input logic [8:0] y, input logic [31:0] re,
                           input logic [31:0] im, input logic jul, input logic [31:0] jre,
                           input logic [31:0] jim, input logic [9:0] mi, output int lat);
    in_x = x; in_y = y; in_re_p = re; in_im_p = im; in_julia = jul;
    jul_re = jre; jul_im = jim; max_iter = mi; in_valid = 1'b1;
    @(posedge sysclk); #1;
    in_valid = 1'b0;
    in_x = 10'h155; in_y = 9'h0AA; in_re_p = 32'h1234_5678; in_im_p = 32'h8765_4321;
    in_julia = ~jul; jul_re = 32'h0BAD_0000; jul_im = 32'h0BAD_0000; max_iter = 10'd3;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge sysclk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    @(posedge sysclk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 reset = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if ({out_x, out_y, out_depth, out_escaped} !== 30'd0)
      begin bad++; $display("FAIL reset_outputs got=%h/%h/%h/%b want=0", out_x, out_y, out_depth, out_escaped); end
  endtask

  task automatic test_mandel_origin();
    int lat;
    start_job(10'd1, 9'd2, FX_0, FX_0, 1'b0, FX_0, FX_0, 10'd10, lat);
    total++; if (lat != 11) begin bad++; $display("FAIL origin_latency got=%0d want=11", lat); end
    total++; if (out_depth !== 10'd10) begin bad++; $display("FAIL origin_depth got=%0d want=10", out_depth); end
    total++; if (out_escaped !== 1'b0) begin bad++; $display("FAIL origin_escaped got=%b want=0", out_escaped); end
    total++; if (out_x !== 10'd1 || out_y !== 9'd2)
      begin bad++; $display("FAIL origin_tags got=%0d,%0d want=1,2", out_x, out_y); end
    finish_job();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL origin_handshake got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_mandel_escape();
    int lat;
    start_job(10'd3, 9'd4, FX_3, FX_0, 1'b0, FX_0, FX_0, 10'd10, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL c3_latency got=%0d want=2", lat); end
    total++; if (out_depth !== 10'd1 || out_escaped !== 1'b1)
      begin bad++; $display("FAIL c3_result got=%0d/%b want=1/1", out_depth, out_escaped); end
    finish_job();
    start_job(10'd5, 9'd6, FX_2, FX_0, 1'b0, FX_0, FX_0, 10'd10, lat);
    total++; if (lat != 3) begin bad++; $display("FAIL c2_latency got=%0d want=3", lat); end
    total++; if (out_depth !== 10'd2 || out_escaped !== 1'b1)
      begin bad++; $display("FAIL c2_result got=%0d/%b want=2/1", out_depth, out_escaped); end
    total++; if (out_x !== 10'd5 || out_y !== 9'd6)
      begin bad++; $display("FAIL c2_tags got=%0d,%0d want=5,6", out_x, out_y); end
    finish_job();
  endtask

  task automatic test_boundary_minus2();
    int lat;
    start_job(10'd7, 9'd8, FX_M2, FX_0, 1'b0, FX_0, FX_0, 10'd50, lat);
    total++; if (lat != 51) begin bad++; $display("FAIL m2_latency got=%0d want=51", lat); end
    total++; if (out_depth !== 10'd50 || out_escaped !== 1'b0)
      begin bad++; $display("FAIL m2_result got=%0d/%b want=50/0", out_depth, out_escaped); end
    finish_job();
  endtask

  task automatic test_julia_and_zero_max();
    int lat;
    start_job(10'd9, 9'd10, FX_3, FX_0, 1'b1, FX_0, FX_0, 10'd10, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL julia_latency got=%0d want=1", lat); end
    total++; if (out_depth !== 10'd0 || out_escaped !== 1'b1)
      begin bad++; $display("FAIL julia_result got=%0d/%b want=0/1", out_depth, out_escaped); end
    finish_job();
    start_job(10'd11, 9'd12, FX_3, FX_0, 1'b0, FX_0, FX_0, 10'd0, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL max0_latency got=%0d want=1", lat); end
    total++; if (out_depth !== 10'd0 || out_escaped !== 1'b0)
      begin bad++; $display("FAIL max0_result got=%0d/%b want=0/0", out_depth, out_escaped); end
    finish_job();
  endtask

  task automatic test_saturation();
    int lat;
    start_job(10'd13, 9'd14, FX_30K, FX_30K, 1'b0, FX_0, FX_0, 10'd5, lat);
    total++; if (lat != 2 || out_depth !== 10'd1 || out_escaped !== 1'b1)
      begin bad++; $display("FAIL sat30k got lat=%0d %0d/%b want lat=2 1/1", lat, out_depth, out_escaped); end
    finish_job();
    // 1.5^2 + 32767.0 overflows the word and must clamp, still escaping next step.
    start_job(10'd15, 9'd16, FX_1P5, FX_0, 1'b1, FX_BIG, FX_0, 10'd5, lat);
    total++; if (lat != 2 || out_depth !== 10'd1 || out_escaped !== 1'b1)
      begin bad++; $display("FAIL satclamp got lat=%0d %0d/%b want lat=2 1/1", lat, out_depth, out_escaped); end
    finish_job();
  endtask

  task automatic test_backpressure();
    int lat;
    start_job(10'd17, 9'd18, FX_2, FX_0, 1'b0, FX_0, FX_0, 10'd10, lat);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge sysclk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_depth !== 10'd2 || out_escaped !== 1'b1 ||
          out_x !== 10'd17 || out_y !== 9'd18)
        begin bad++; $display("FAIL hold_cycle%0d got v=%b r=%b d=%0d e=%b x=%0d y=%0d want v=1 r=0 d=2 e=1 x=17 y=18",
                              i, out_valid, in_ready, out_depth, out_escaped, out_x, out_y); end
    end
    in_valid = 1'b0;
    finish_job();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL hold_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_iter();
    int lat;
    in_x = 10'd20; in_y = 9'd21; in_re_p = FX_0; in_im_p = FX_0; in_julia = 1'b0;
    max_iter = 10'd100; in_valid = 1'b1;
    @(posedge sysclk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge sysclk);
    #1 reset = 1'b1;
    @(posedge sysclk); #1;
    reset = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_depth !== 10'd0)
      begin bad++; $display("FAIL midreset got v=%b r=%b d=%0d want v=0 r=1 d=0", out_valid, in_ready, out_depth); end
    start_job(10'd639, 9'd479, FX_2, FX_0, 1'b0, FX_0, FX_0, 10'd10, lat);
    total++; if (lat != 3 || out_depth !== 10'd2 || out_escaped !== 1'b1)
      begin bad++; $display("FAIL post_reset_job got lat=%0d %0d/%b want lat=3 2/1", lat, out_depth, out_escaped); end
    total++; if (out_x !== 10'd639 || out_y !== 9'd479)
      begin bad++; $display("FAIL post_reset_tags got=%0d,%0d want=639,479", out_x, out_y); end
    finish_job();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_re_p = '0; in_im_p = '0; in_julia = 1'b0;
    jul_re = '0; jul_im = '0; max_iter = '0;
    test_reset();
    test_mandel_origin();
    test_mandel_escape();
    test_boundary_minus2();
    test_julia_and_zero_max();
    test_saturation();
    test_backpressure();
    test_reset_mid_iter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
